// File: rtl/myc64_i2s_tx_if.sv
// Stereo PCM sample handshake plus serial DAC pins for myc64_i2s_tx.
// Latency: none (signal bundle only).
// Backpressure: source holds i_valid/i_left/i_right until a cycle with o_ready high.
// Signals: i_enable, i_valid, i_left, i_right (source -> transmitter);
//          o_ready, o_mclk, o_bclk, o_lrclk, o_sdata, o_underrun (transmitter -> source/pins);
//          o_level, o_underrun_cnt only when MYC64_I2S_TX_STATUS_EN is defined.
interface myc64_i2s_tx_if #(
  parameter int SAMPLE_WIDTH = 16
`ifdef MYC64_I2S_TX_STATUS_EN
  , parameter int FIFO_DEPTH = 4
`endif
);
  logic                    i_enable;
  logic                    i_valid;
  logic                    o_ready;
  logic [SAMPLE_WIDTH-1:0] i_left;
  logic [SAMPLE_WIDTH-1:0] i_right;
  logic                    o_mclk;
  logic                    o_bclk;
  logic                    o_lrclk;
  logic                    o_sdata;
  logic                    o_underrun;
`ifdef MYC64_I2S_TX_STATUS_EN
  logic [$clog2(FIFO_DEPTH+1)-1:0] o_level;
  logic [15:0]                     o_underrun_cnt;
`endif

  modport master (
    output i_enable, i_valid, i_left, i_right,
    input  o_ready, o_mclk, o_bclk, o_lrclk, o_sdata, o_underrun
`ifdef MYC64_I2S_TX_STATUS_EN
    , input o_level, o_underrun_cnt
`endif
  );

  modport slave (
    input  i_enable, i_valid, i_left, i_right,
    output o_ready, o_mclk, o_bclk, o_lrclk, o_sdata, o_underrun
`ifdef MYC64_I2S_TX_STATUS_EN
    , output o_level, o_underrun_cnt
`endif
  );
endinterface

// File: rtl/myc64_i2s_tx.sv
// I2S / left-justified stereo transmitter with a stereo-pair FIFO, MCLK/BCLK/LRCLK by 2^n division.
// Latency: pins are registered one clk behind the frame counter; a pushed pair plays from the next frame start.
// Backpressure: o_ready (registered, = !full) gates pushes; an empty FIFO at frame start raises o_underrun.
// Ports: clk, rst (async, active high); bus (slave modport of myc64_i2s_tx_if) carrying
//        i_enable, i_valid/o_ready, i_left/i_right, o_mclk/o_bclk/o_lrclk/o_sdata, o_underrun.
// Optional build macro MYC64_I2S_TX_STATUS_EN adds o_level and o_underrun_cnt.
// SLOT_WIDTH and FIFO_DEPTH are expected to be powers of two, SLOT_WIDTH >= 2.
module myc64_i2s_tx #(
  parameter int SAMPLE_WIDTH  = 16,
  parameter int SLOT_WIDTH    = 16,
  parameter int MCLK_DIV_LOG2 = 1,
  parameter int BCLK_DIV_LOG2 = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int FORMAT        = 0,
  parameter int UNDERRUN_ZERO = 1
) (
  input  logic          clk,
  input  logic          rst,
  myc64_i2s_tx_if.slave bus
);
  localparam int K_W   = $clog2(2*SLOT_WIDTH);
  localparam int CW    = BCLK_DIV_LOG2 + K_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH+1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic [CW-1:0]           cntr;
  logic [K_W-1:0]          k;
  logic                    fetch, push, pop, empty;
  logic [LVL_W-1:0]        level, level_nxt;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic                    ready_q;
  logic [SAMPLE_WIDTH-1:0] mem_l [FIFO_DEPTH];
  logic [SAMPLE_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [SAMPLE_WIDTH-1:0] hold_l, hold_r, hold_l_nxt, hold_r_nxt;
  logic [SLOT_WIDTH-1:0]   shreg, shreg_nxt, load_val;
  logic                    bit_start, slot_start, slot_right, lj_bit;
  logic                    carry_q;
  logic                    mclk_q, bclk_q, lrclk_q, sdata_q, underrun_q;

  // Frame counter: low BCLK_DIV_LOG2 bits time one bit period, upper bits index the bit in the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntr <= '0;
    end else if (bus.i_enable) begin
      cntr <= cntr + CW'(1);
    end else begin
      cntr <= '0;
    end
  end

  assign fetch = bus.i_enable && (cntr == '1);
  assign empty = (level == '0);
  assign push  = bus.i_valid && ready_q;
  assign pop   = fetch && !empty;

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
  end

  // Hold regs carry the pair of the frame now playing; they change only at the frame fetch.
  always_comb begin
    hold_l_nxt = hold_l;
    hold_r_nxt = hold_r;
    if (pop) begin
      hold_l_nxt = mem_l[rd_ptr];
      hold_r_nxt = mem_r[rd_ptr];
    end else if (fetch && (UNDERRUN_ZERO != 0)) begin
      hold_l_nxt = '0;
      hold_r_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_l[wr_ptr] <= bus.i_left;
      mem_r[wr_ptr] <= bus.i_right;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      ready_q <= 1'b1;
      hold_l  <= '0;
      hold_r  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level   <= level_nxt;
      ready_q <= (level_nxt != LVL_FULL);
      hold_l  <= hold_l_nxt;
      hold_r  <= hold_r_nxt;
    end
  end

  // Serial path. shreg always produces the left-justified bit order; I2S is the same
  // stream delayed by one bit period through carry_q, which is what makes slot bit 0
  // carry the previous slot's final bit, including across the frame wrap.
  assign k          = cntr[CW-1:BCLK_DIV_LOG2];
  assign bit_start  = bus.i_enable && (cntr[BCLK_DIV_LOG2-1:0] == '0);
  assign slot_right = k[K_W-1];
  assign slot_start = (k[K_W-2:0] == '0);

  always_comb begin
    load_val = '0;
    load_val[SLOT_WIDTH-1 -: SAMPLE_WIDTH] = slot_right ? hold_r : hold_l;
    if (slot_start) begin
      lj_bit    = load_val[SLOT_WIDTH-1];
      shreg_nxt = {load_val[SLOT_WIDTH-2:0], 1'b0};
    end else begin
      lj_bit    = shreg[SLOT_WIDTH-1];
      shreg_nxt = {shreg[SLOT_WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg      <= '0;
      carry_q    <= 1'b0;
      mclk_q     <= 1'b0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= fetch && empty;
      if (!bus.i_enable) begin
        mclk_q  <= 1'b0;
        bclk_q  <= 1'b0;
        lrclk_q <= 1'b0;
        sdata_q <= 1'b0;
      end else begin
        mclk_q  <= cntr[MCLK_DIV_LOG2-1];
        bclk_q  <= cntr[BCLK_DIV_LOG2-1];
        lrclk_q <= cntr[CW-1];
        if (bit_start) begin
          shreg <= shreg_nxt;
          if (FORMAT == 1) begin
            sdata_q <= lj_bit;
          end else begin
            sdata_q <= carry_q;
            carry_q <= lj_bit;
          end
        end
      end
    end
  end

  assign bus.o_ready    = ready_q;
  assign bus.o_mclk     = mclk_q;
  assign bus.o_bclk     = bclk_q;
  assign bus.o_lrclk    = lrclk_q;
  assign bus.o_sdata    = sdata_q;
  assign bus.o_underrun = underrun_q;

`ifdef MYC64_I2S_TX_STATUS_EN
  logic [15:0] underrun_cnt;

  // Saturating so a long-running stall cannot wrap back to a small count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if (fetch && empty && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end

  assign bus.o_level        = level;
  assign bus.o_underrun_cnt = underrun_cnt;
`endif
endmodule

// File: tb/tb_myc64_i2s_tx.sv
`timescale 1ns/1ps
module tb_myc64_i2s_tx;
  localparam int BD = 4;
  localparam int MD = 1;
  localparam int SL = 16;
  localparam int FD = 4;
  localparam int F  = (2*SL) << BD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        vld = 1'b0;
  logic [15:0] dl  = '0;
  logic [15:0] dr  = '0;

  always #5 clk = ~clk;

  myc64_i2s_tx_if #(.SAMPLE_WIDTH(16)
`ifdef MYC64_I2S_TX_STATUS_EN
    , .FIFO_DEPTH(FD)
`endif
  ) bus0 ();
  myc64_i2s_tx_if #(.SAMPLE_WIDTH(12)
`ifdef MYC64_I2S_TX_STATUS_EN
    , .FIFO_DEPTH(FD)
`endif
  ) bus1 ();

  assign bus0.i_enable = en;
  assign bus0.i_valid  = vld;
  assign bus0.i_left   = dl;
  assign bus0.i_right  = dr;
  assign bus1.i_enable = en;
  assign bus1.i_valid  = vld;
  assign bus1.i_left   = dl[11:0];
  assign bus1.i_right  = dr[11:0];

  // I2S, full-width samples, zero on underrun
  myc64_i2s_tx dut0 (.clk(clk), .rst(rst), .bus(bus0));
  // left-justified, 12-bit samples in 16-bit slots, repeat last frame on underrun
  myc64_i2s_tx #(.SAMPLE_WIDTH(12), .FORMAT(1), .UNDERRUN_ZERO(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Reference model: frame position, a queue of accepted pairs, and the pair each DUT is playing.
  int          t;
  int          ucnt_m;
  int          n_chk;
  int          n_fail;
  logic [15:0] q_l[$];
  logic [15:0] q_r[$];
  logic [15:0] h0l, h0r, h1l, h1r;
  logic        carry0;
  logic        skip_carry;
  logic        ready_m;
  logic        e_mclk, e_bclk, e_lr, e_sd0, e_sd1, e_und, e_chk_sd0;

  // Expected serial bit at frame position c, straight from the slot-bit rules.
  function automatic logic slot_bit(input int fmt, input int sw, input logic [15:0] l,
                                    input logic [15:0] r, input logic carry, input int c);
    int          k;
    int          j;
    logic [15:0] x;
    k = c >> BD;
    j = k % SL;
    x = (k >= SL) ? r : l;
    if (fmt == 1) return (j < sw) ? x[sw-1-j] : 1'b0;
    if (j == 0) begin
      if (k < SL) return carry;
      return (sw == SL) ? l[0] : 1'b0;
    end
    return (j <= sw) ? x[sw-j] : 1'b0;
  endfunction

  task automatic reset_model();
    t = 0;
    q_l.delete();
    q_r.delete();
    h0l = '0; h0r = '0; h1l = '0; h1r = '0;
    carry0 = 1'b0;
    skip_carry = 1'b0;
    ready_m = 1'b1;
    ucnt_m = 0;
    e_mclk = 0; e_bclk = 0; e_lr = 0; e_sd0 = 0; e_sd1 = 0; e_und = 0; e_chk_sd0 = 1;
  endtask

  // One clock of the model, using the input values present at the rising edge.
  task automatic model_step();
    logic fetch, was_empty, push;
    if (rst) begin
      reset_model();
      return;
    end
    push  = vld && ready_m;
    fetch = 1'b0;
    if (en) begin
      e_mclk    = ((t >> (MD-1)) % 2) == 1;
      e_bclk    = ((t >> (BD-1)) % 2) == 1;
      e_lr      = (t >= F/2);
      e_sd0     = slot_bit(0, 16, h0l, h0r, carry0, t);
      e_sd1     = slot_bit(1, 12, h1l, h1r, 1'b0, t);
      e_chk_sd0 = !(skip_carry && (t < (1 << BD)));
      fetch     = (t == F-1);
      t         = (t + 1) % F;
    end else begin
      if (t != 0) skip_carry = 1'b1;
      e_mclk = 0; e_bclk = 0; e_lr = 0; e_sd0 = 0; e_sd1 = 0; e_chk_sd0 = 1;
      t = 0;
    end
    was_empty = (q_l.size() == 0);
    e_und = fetch && was_empty;
    if (fetch) begin
      carry0 = h0r[0];
      skip_carry = 1'b0;
      if (!was_empty) begin
        h0l = q_l.pop_front();
        h0r = q_r.pop_front();
        h1l = h0l;
        h1r = h0r;
      end else begin
        h0l = '0;
        h0r = '0;
        if (ucnt_m < 65535) ucnt_m++;
      end
    end
    if (push) begin
      q_l.push_back(dl);
      q_r.push_back(dr);
    end
    ready_m = (q_l.size() != FD);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("ready0", {15'b0, bus0.o_ready},    {15'b0, ready_m});
    chk("ready1", {15'b0, bus1.o_ready},    {15'b0, ready_m});
    chk("mclk0",  {15'b0, bus0.o_mclk},     {15'b0, e_mclk});
    chk("bclk0",  {15'b0, bus0.o_bclk},     {15'b0, e_bclk});
    chk("lrclk0", {15'b0, bus0.o_lrclk},    {15'b0, e_lr});
    if (e_chk_sd0) chk("sdata0", {15'b0, bus0.o_sdata}, {15'b0, e_sd0});
    chk("under0", {15'b0, bus0.o_underrun}, {15'b0, e_und});
    chk("mclk1",  {15'b0, bus1.o_mclk},     {15'b0, e_mclk});
    chk("bclk1",  {15'b0, bus1.o_bclk},     {15'b0, e_bclk});
    chk("lrclk1", {15'b0, bus1.o_lrclk},    {15'b0, e_lr});
    chk("sdata1", {15'b0, bus1.o_sdata},    {15'b0, e_sd1});
    chk("under1", {15'b0, bus1.o_underrun}, {15'b0, e_und});
`ifdef MYC64_I2S_TX_STATUS_EN
    chk("level0", 16'(bus0.o_level),   16'(q_l.size()));
    chk("level1", 16'(bus1.o_level),   16'(q_l.size()));
    chk("ucnt0",  bus0.o_underrun_cnt, 16'(ucnt_m));
    chk("ucnt1",  bus1.o_underrun_cnt, 16'(ucnt_m));
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    logic accepted;
    accepted = 1'b0;
    vld = 1'b1;
    dl  = l;
    dr  = r;
    for (int i = 0; i < 4*F && !accepted; i++) begin
      accepted = ready_m;
      cycle();
    end
    vld = 1'b0;
    chk("push_accept", {15'b0, accepted}, 16'd1);
  endtask

  task automatic push_random();
    logic [15:0] l, r;
    l = 16'($urandom);
    r = 16'($urandom);
    push_pair(l, r);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset_model();

    // reset state
    repeat (3) @(negedge clk);
    check_all();
    rst = 1'b0;

    // idle stream: clock periods, underrun once per frame, zero data
    en = 1'b1;
    run(2*F);

    // directed pairs; the following frames underrun (dut1 repeats the last pair)
    push_pair(16'hA5F0, 16'h8001);
    run(2*F);
    push_pair(16'h0ABC, 16'h0123);
    run(3*F);

    // five pairs back to back into a depth-4 FIFO
    for (int i = 0; i < 5; i++) push_random();
    run(6*F);

    // push into an empty FIFO on the fetch clk
    for (int i = 0; i < F && t != F-1; i++) cycle();
    push_pair(16'h7FFF, 16'h8000);
    run(2*F);

    // random push timing
    for (int i = 0; i < 8; i++) begin
      run(int'($urandom_range(0, 700)));
      push_random();
    end
    run(3*F);

    // disable mid-slot, queue while disabled, then resume
    run(200);
    en = 1'b0;
    run(40);
    push_random();
    push_random();
    run(20);
    en = 1'b1;
    run(F + 100);

    // asynchronous reset mid-frame
    push_random();
    run(37);
    rst = 1'b1;
    reset_model();
    #1;
    check_all();
    run(5);
    rst = 1'b0;
    run(F);
    push_random();
    run(2*F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
